// File: rtl/ahb_sys_pkg.sv
// Shared constants for the Cortex-M3 system-bus slave mux: slave indices,
// HTRANS encodings and the default-slave state encoding.
package ahb_sys_pkg;

  localparam int NSLV = 8;

  localparam int IDX_RAM   = 0;
  localparam int IDX_APB   = 1;
  localparam int IDX_ADC   = 2;
  localparam int IDX_FFT   = 3;
  localparam int IDX_MAC   = 4;
  localparam int IDX_MAC_1 = 5;
  localparam int IDX_LOG   = 6;
  localparam int IDX_DEF   = 7;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR for NONSEQ/SEQ,
// zero-wait OKAY for IDLE/BUSY. Read data is always zero.
module ahb_default_slave
  import ahb_sys_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsel,
  input  logic [1:0]    htrans,
  input  logic          hready,
  output logic          hreadyout,
  output logic          hresp,
  output logic [DW-1:0] hrdata
);

  ds_state_e state, state_nxt;
  logic      active;
  logic      err_req;

  assign active  = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  assign err_req = hsel && active && hready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DS_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      DS_IDLE: if (err_req) state_nxt = DS_ERR1;
      DS_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = DS_ERR2;
      end
      DS_ERR2: begin
        hresp     = 1'b1;
        // chaining straight into ERR1 keeps back-to-back errors gap-free
        state_nxt = err_req ? DS_ERR1 : DS_IDLE;
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

  assign hrdata = '0;

endmodule

// File: rtl/ahb_slave_mux_system.sv
// AHB-Lite data-phase slave mux: registers the decoder's one-hot select in the
// address phase and steers the chosen slave's ready/resp/rdata back to the master.
module ahb_slave_mux_system #(
  parameter int DW   = 32,
  parameter int NSLV = 8
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL_RAM,
  input  logic          HSEL_APB,
  input  logic          HSEL_CM3_ADC,
  input  logic          HSEL_CM3_FFT,
  input  logic          HSEL_CM3_MAC,
  input  logic          HSEL_CM3_MAC_1,
  input  logic          HSEL_CM3_LOG,
  input  logic          HSEL_DefSlave,
  input  logic [1:0]    HTRANS,
  input  logic          HREADYOUT_RAM,
  input  logic          HREADYOUT_APB,
  input  logic          HREADYOUT_CM3_ADC,
  input  logic          HREADYOUT_CM3_FFT,
  input  logic          HREADYOUT_CM3_MAC,
  input  logic          HREADYOUT_CM3_MAC_1,
  input  logic          HREADYOUT_CM3_LOG,
  input  logic          HRESP_RAM,
  input  logic          HRESP_APB,
  input  logic          HRESP_CM3_ADC,
  input  logic          HRESP_CM3_FFT,
  input  logic          HRESP_CM3_MAC,
  input  logic          HRESP_CM3_MAC_1,
  input  logic          HRESP_CM3_LOG,
  input  logic [DW-1:0] HRDATA_RAM,
  input  logic [DW-1:0] HRDATA_APB,
  input  logic [DW-1:0] HRDATA_CM3_ADC,
  input  logic [DW-1:0] HRDATA_CM3_FFT,
  input  logic [DW-1:0] HRDATA_CM3_MAC,
  input  logic [DW-1:0] HRDATA_CM3_MAC_1,
  input  logic [DW-1:0] HRDATA_CM3_LOG,
  output logic          HREADY,
  output logic          HRESP,
  output logic [DW-1:0] HRDATA
);
  import ahb_sys_pkg::*;

  logic [NSLV-1:0]         sel_d, sel_q;
  logic [NSLV-1:0]         rdy_v, rsp_v;
  logic [NSLV-1:0][DW-1:0] dat_v;
  logic                    def_ready, def_resp;
  logic [DW-1:0]           def_rdata;

  assign sel_d = {HSEL_DefSlave, HSEL_CM3_LOG, HSEL_CM3_MAC_1, HSEL_CM3_MAC,
                  HSEL_CM3_FFT, HSEL_CM3_ADC, HSEL_APB, HSEL_RAM};

  assign rdy_v = {def_ready, HREADYOUT_CM3_LOG, HREADYOUT_CM3_MAC_1, HREADYOUT_CM3_MAC,
                  HREADYOUT_CM3_FFT, HREADYOUT_CM3_ADC, HREADYOUT_APB, HREADYOUT_RAM};
  assign rsp_v = {def_resp, HRESP_CM3_LOG, HRESP_CM3_MAC_1, HRESP_CM3_MAC,
                  HRESP_CM3_FFT, HRESP_CM3_ADC, HRESP_APB, HRESP_RAM};

  assign dat_v[IDX_RAM]   = HRDATA_RAM;
  assign dat_v[IDX_APB]   = HRDATA_APB;
  assign dat_v[IDX_ADC]   = HRDATA_CM3_ADC;
  assign dat_v[IDX_FFT]   = HRDATA_CM3_FFT;
  assign dat_v[IDX_MAC]   = HRDATA_CM3_MAC;
  assign dat_v[IDX_MAC_1] = HRDATA_CM3_MAC_1;
  assign dat_v[IDX_LOG]   = HRDATA_CM3_LOG;
  assign dat_v[IDX_DEF]   = def_rdata;

  // Select only advances when the current data phase completes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)      sel_q <= '0;
    else if (HREADY) sel_q <= sel_d;
  end

  // Scan high-to-low so the lowest set index overrides: fixed priority on multi-hot.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (sel_q[i]) begin
        HREADY = rdy_v[i];
        HRESP  = rsp_v[i];
        HRDATA = dat_v[i];
      end
    end
  end

  ahb_default_slave #(.DW(DW)) u_def (
    .clk       (HCLK),
    .rst       (HRESET),
    .hsel      (HSEL_DefSlave),
    .htrans    (HTRANS),
    .hready    (HREADY),
    .hreadyout (def_ready),
    .hresp     (def_resp),
    .hrdata    (def_rdata)
  );

endmodule

// File: tb/tb_ahb_slave_mux_system.sv
// Directed bench for the AHB slave mux: reset, real-slave reads, wait states,
// default-slave error sequencing, reset mid-error and multi-hot priority.
module tb_ahb_slave_mux_system;
  import ahb_sys_pkg::*;

  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSEL_RAM, HSEL_APB, HSEL_CM3_ADC, HSEL_CM3_FFT;
  logic          HSEL_CM3_MAC, HSEL_CM3_MAC_1, HSEL_CM3_LOG, HSEL_DefSlave;
  logic [1:0]    HTRANS;
  logic          HREADYOUT_RAM, HREADYOUT_APB, HREADYOUT_CM3_ADC, HREADYOUT_CM3_FFT;
  logic          HREADYOUT_CM3_MAC, HREADYOUT_CM3_MAC_1, HREADYOUT_CM3_LOG;
  logic          HRESP_RAM, HRESP_APB, HRESP_CM3_ADC, HRESP_CM3_FFT;
  logic          HRESP_CM3_MAC, HRESP_CM3_MAC_1, HRESP_CM3_LOG;
  logic [DW-1:0] HRDATA_RAM, HRDATA_APB, HRDATA_CM3_ADC, HRDATA_CM3_FFT;
  logic [DW-1:0] HRDATA_CM3_MAC, HRDATA_CM3_MAC_1, HRDATA_CM3_LOG;
  logic          HREADY, HRESP;
  logic [DW-1:0] HRDATA;

  int checks = 0;
  int fails  = 0;

  always #5 HCLK = ~HCLK;

  ahb_slave_mux_system #(.DW(DW), .NSLV(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSEL_RAM(HSEL_RAM), .HSEL_APB(HSEL_APB), .HSEL_CM3_ADC(HSEL_CM3_ADC),
    .HSEL_CM3_FFT(HSEL_CM3_FFT), .HSEL_CM3_MAC(HSEL_CM3_MAC),
    .HSEL_CM3_MAC_1(HSEL_CM3_MAC_1), .HSEL_CM3_LOG(HSEL_CM3_LOG),
    .HSEL_DefSlave(HSEL_DefSlave), .HTRANS(HTRANS),
    .HREADYOUT_RAM(HREADYOUT_RAM), .HREADYOUT_APB(HREADYOUT_APB),
    .HREADYOUT_CM3_ADC(HREADYOUT_CM3_ADC), .HREADYOUT_CM3_FFT(HREADYOUT_CM3_FFT),
    .HREADYOUT_CM3_MAC(HREADYOUT_CM3_MAC), .HREADYOUT_CM3_MAC_1(HREADYOUT_CM3_MAC_1),
    .HREADYOUT_CM3_LOG(HREADYOUT_CM3_LOG),
    .HRESP_RAM(HRESP_RAM), .HRESP_APB(HRESP_APB), .HRESP_CM3_ADC(HRESP_CM3_ADC),
    .HRESP_CM3_FFT(HRESP_CM3_FFT), .HRESP_CM3_MAC(HRESP_CM3_MAC),
    .HRESP_CM3_MAC_1(HRESP_CM3_MAC_1), .HRESP_CM3_LOG(HRESP_CM3_LOG),
    .HRDATA_RAM(HRDATA_RAM), .HRDATA_APB(HRDATA_APB), .HRDATA_CM3_ADC(HRDATA_CM3_ADC),
    .HRDATA_CM3_FFT(HRDATA_CM3_FFT), .HRDATA_CM3_MAC(HRDATA_CM3_MAC),
    .HRDATA_CM3_MAC_1(HRDATA_CM3_MAC_1), .HRDATA_CM3_LOG(HRDATA_CM3_LOG),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check the ready/resp pair as a 2-bit value {HREADY, HRESP}.
  task automatic chk_rr(input string tag, input logic [1:0] exp);
    chk(tag, {30'd0, HREADY, HRESP}, {30'd0, exp});
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic clr_sel();
    {HSEL_RAM, HSEL_APB, HSEL_CM3_ADC, HSEL_CM3_FFT,
     HSEL_CM3_MAC, HSEL_CM3_MAC_1, HSEL_CM3_LOG, HSEL_DefSlave} = '0;
  endtask

  initial begin
    HRESET = 1'b1;
    clr_sel();
    HTRANS = HTRANS_IDLE;
    {HREADYOUT_RAM, HREADYOUT_APB, HREADYOUT_CM3_ADC, HREADYOUT_CM3_FFT,
     HREADYOUT_CM3_MAC, HREADYOUT_CM3_MAC_1, HREADYOUT_CM3_LOG} = '1;
    {HRESP_RAM, HRESP_APB, HRESP_CM3_ADC, HRESP_CM3_FFT,
     HRESP_CM3_MAC, HRESP_CM3_MAC_1, HRESP_CM3_LOG} = '0;
    HRDATA_RAM = 32'h1234_5678; HRDATA_APB = 32'h0; HRDATA_CM3_ADC = 32'h0;
    HRDATA_CM3_FFT = 32'h0; HRDATA_CM3_MAC = 32'h0; HRDATA_CM3_MAC_1 = 32'h0;
    HRDATA_CM3_LOG = 32'h0;

    // Reset state: nothing selected even though slaves drive data.
    tick();
    chk_rr("reset_rr", 2'b10);
    chk("reset_data", HRDATA, 32'h0);
    HRESET = 1'b0;
    tick();
    chk_rr("post_reset_rr", 2'b10);

    // RAM read.
    HSEL_RAM = 1'b1; HTRANS = HTRANS_NONSEQ;
    tick();
    clr_sel(); HTRANS = HTRANS_IDLE; HRDATA_RAM = 32'hDEAD_BEEF;
    #1;
    chk("ram_data", HRDATA, 32'hDEAD_BEEF);
    chk_rr("ram_rr", 2'b10);
    tick();

    // APB with 3 wait states; decoder moves to FFT during the wait.
    HSEL_APB = 1'b1; HTRANS = HTRANS_NONSEQ;
    tick();
    clr_sel(); HSEL_CM3_FFT = 1'b1;
    HREADYOUT_APB = 1'b0; HRDATA_CM3_FFT = 32'hFFFF_0000;
    for (int w = 0; w < 3; w++) begin
      HRDATA_APB = 32'h1111_1111 * (w + 1);
      #1;
      chk($sformatf("apb_wait%0d_ready", w), {31'd0, HREADY}, 32'd0);
      chk($sformatf("apb_wait%0d_data", w), HRDATA, 32'h1111_1111 * (w + 1));
      tick();
    end
    HREADYOUT_APB = 1'b1; HRDATA_APB = 32'hA0B0_C0D0;
    #1;
    chk_rr("apb_done_rr", 2'b10);
    chk("apb_done_data", HRDATA, 32'hA0B0_C0D0);
    tick();
    clr_sel(); HTRANS = HTRANS_IDLE;
    #1;
    chk("fft_after_wait", HRDATA, 32'hFFFF_0000);
    tick();

    // Unmapped NONSEQ: 0/1 then 1/1 then OKAY.
    HSEL_DefSlave = 1'b1; HTRANS = HTRANS_NONSEQ;
    tick();
    clr_sel(); HTRANS = HTRANS_IDLE;
    #1;
    chk_rr("unmap_err1", 2'b01);
    chk("unmap_data", HRDATA, 32'h0);
    tick();
    chk_rr("unmap_err2", 2'b11);
    tick();
    chk_rr("unmap_idle", 2'b10);

    // Back-to-back SEQ errors, then IDLE transfer to default slave.
    HSEL_DefSlave = 1'b1; HTRANS = HTRANS_SEQ;
    tick();
    chk_rr("b2b_err1a", 2'b01);
    tick();
    chk_rr("b2b_err2a", 2'b11);
    tick();
    chk_rr("b2b_err1b", 2'b01);
    HTRANS = HTRANS_IDLE;
    tick();
    chk_rr("b2b_err2b", 2'b11);
    tick();
    chk_rr("def_idle_okay", 2'b10);
    clr_sel();
    tick();

    // Reset in the middle of ERR1.
    HSEL_DefSlave = 1'b1; HTRANS = HTRANS_NONSEQ;
    tick();
    chk_rr("pre_rst_err1", 2'b01);
    HRESET = 1'b1;
    #1;
    chk_rr("rst_mid_err1", 2'b10);
    chk("rst_mid_err1_data", HRDATA, 32'h0);
    clr_sel(); HTRANS = HTRANS_IDLE;
    tick();
    HRESET = 1'b0;
    #1;
    chk_rr("after_rst_sel0", 2'b10);
    // FSM must be IDLE: a non-erroring select of default slave gives OKAY.
    HSEL_DefSlave = 1'b1;
    tick();
    chk_rr("after_rst_fsm_idle", 2'b10);
    clr_sel();
    tick();

    // Multi-hot RAM + LOG: RAM wins.
    HSEL_RAM = 1'b1; HSEL_CM3_LOG = 1'b1; HTRANS = HTRANS_NONSEQ;
    tick();
    clr_sel(); HTRANS = HTRANS_IDLE;
    HRDATA_RAM = 32'hA5A5_A5A5; HRDATA_CM3_LOG = 32'h5A5A_5A5A;
    HREADYOUT_CM3_LOG = 1'b0; HRESP_RAM = 1'b1;
    #1;
    chk("multihot_data", HRDATA, 32'hA5A5_A5A5);
    chk_rr("multihot_rr", 2'b11);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mux_system.md
# ahb_slave_mux_system

AHB-Lite data-phase slave multiplexer with an integrated default slave for the Cortex-M3 system bus. Sits directly downstream of the system address decoder. It latches the one-hot slave select during the address phase and steers the selected slave's HRDATA, HREADYOUT and HRESP back to the master during the data phase. It also answers unmapped accesses with a two-cycle AHB ERROR response.

## Interface
Parameters:
- DW, 32, data width of HRDATA paths
- NSLV, 8, number of slave ports, fixed index order: RAM=0, APB=1, CM3_ADC=2, CM3_FFT=3, CM3_MAC=4, CM3_MAC_1=5, CM3_LOG=6, DefSlave=7

Ports:
- HCLK  in  1  system bus clock
- HRESET  in  1  asynchronous, active-high reset
- HSEL_RAM, HSEL_APB, HSEL_CM3_ADC, HSEL_CM3_FFT, HSEL_CM3_MAC, HSEL_CM3_MAC_1, HSEL_CM3_LOG, HSEL_DefSlave  in  1 each  address-phase selects from the decoder
- HTRANS  in  2  master transfer type
- HREADYOUT_<slave>  in  1 each  ready from the seven real slaves
- HRESP_<slave>  in  1 each  response from the seven real slaves (1 = ERROR)
- HRDATA_<slave>  in  DW each  read data from the seven real slaves
- HREADY  out  1  muxed ready to the master and to all slaves' HREADY inputs
- HRESP  out  1  muxed response
- HRDATA  out  DW  muxed read data

## Operation
- Address-phase capture: on a rising HCLK edge with HREADY=1, sel_q[7:0] <= {HSEL_DefSlave, …, HSEL_RAM}. While HREADY=0, sel_q holds.
- Multi-hot selects are illegal; the lowest index wins, giving deterministic fixed priority.
- All-zero sel_q is the reset state and the state after the decoder glitches; in it the outputs are HREADY=1, HRESP=0, HRDATA=0.
- Data-phase mux: HREADY/HRESP/HRDATA = the selected port's HREADYOUT/HRESP/HRDATA, combinational from sel_q.
- Default slave (port 7), states IDLE, ERR1, ERR2:
  - IDLE → ERR1 when HSEL_DefSlave & HTRANS[1] & HREADY at the edge.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → ERR1 if HSEL_DefSlave & HTRANS[1] & HREADY; otherwise → IDLE.
  - Outputs: IDLE gives HREADYOUT=1, HRESP=0; ERR1 gives HREADYOUT=0, HRESP=1; ERR2 gives HREADYOUT=1, HRESP=1. HRDATA is always 0.
- An IDLE or BUSY transfer (HTRANS[1]=0) to the default slave gets a zero-wait OKAY.
- Reset: sel_q=0 and the FSM goes to IDLE immediately and asynchronously, including mid-ERR1, mid-ERR2 and mid-wait-state. Outputs revert to HREADY=1, HRESP=0, HRDATA=0 in the same cycle.

## Timing
- Select capture latency is 1 cycle: the data phase of a transfer accepted at edge N is muxed from edge N to edge N+1. It extends while the selected HREADYOUT=0.
- The mux adds no registers in the data path: zero added latency, purely combinational from sel_q and the slave outputs.
- The default-slave error response is exactly 2 cycles (one wait plus one completion) per erroring transfer. Back-to-back errors chain as ERR1, ERR2, ERR1, ERR2 with no IDLE between them.
- HRESP from a real slave passes through unmodified. Two-cycle ERROR compliance is the slave's responsibility.
- A select change during a wait state is ignored until HREADY=1.

## Structure
- Package ahb_sys_pkg holds:
  - the slave index constants (IDX_RAM … IDX_DEF)
  - NSLV
  - the default-slave state enum (IDLE=2'b00, ERR1=2'b01, ERR2=2'b10)
  - the HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
- Sub-module ahb_default_slave contains the FSM and drives HREADYOUT/HRESP/HRDATA for port 7. The top contains sel_q and the priority mux.

## Test plan
- Reset: assert HRESET mid-run → HREADY=1, HRESP=0, HRDATA=0 immediately. sel_q=0 and the FSM is IDLE after release.
- RAM read: HSEL_RAM=1, HTRANS=NONSEQ, HREADY=1 at edge N; next cycle HREADYOUT_RAM=1, HRDATA_RAM=32'hDEADBEEF → HRDATA=32'hDEADBEEF, HRESP=0.
- APB wait states:
  - Stimulus: HREADYOUT_APB low for 3 cycles; HSEL switches to CM3_FFT during the wait.
  - Required: HREADY low for 3 cycles; HRDATA tracks HRDATA_APB; sel_q moves to FFT only at the edge where HREADY=1.
- Unmapped NONSEQ: HSEL_DefSlave=1, HTRANS=2'b10 → the next two cycles give HREADY/HRESP = 0/1 then 1/1, then OKAY/IDLE.
- Back-to-back unmapped SEQ plus idle: two consecutive erroring transfers → the pattern 0/1, 1/1, 0/1, 1/1 with no gap. Then HTRANS=IDLE to DefSlave → single-cycle HREADY=1, HRESP=0.
- Reset mid-ERR1 and illegal multi-hot:
  - HRESET asserted while in ERR1 → HREADY=1, HRESP=0 in the same cycle.
  - HSEL_RAM and HSEL_LOG both 1 → RAM data returned.
